// File: rtl/wb_data_arbiter_if.sv
// Bus bundle between three Wishbone classic masters, the arbiter and the shared-RAM data port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface wb_data_arbiter_if #(
  parameter int unsigned DW = 32
);
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic          m2_cyc_i, m2_stb_i, m2_we_i;
  logic [DW-1:0] m0_adr_i, m0_dat_i;
  logic [DW-1:0] m1_adr_i, m1_dat_i;
  logic [DW-1:0] m2_adr_i, m2_dat_i;
  logic          m0_ack_o, m0_err_o;
  logic          m1_ack_o, m1_err_o;
  logic          m2_ack_o, m2_err_o;
  logic [DW-1:0] m0_dat_o, m1_dat_o, m2_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [DW-1:0] s_adr_o, s_dat_o;
  logic          s_ack_i;
  logic [DW-1:0] s_dat_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m2_cyc_i, m2_stb_i, m2_we_i, m2_adr_i, m2_dat_i,
    output m0_ack_o, m0_err_o, m0_dat_o,
    output m1_ack_o, m1_err_o, m1_dat_o,
    output m2_ack_o, m2_err_o, m2_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m2_cyc_i, m2_stb_i, m2_we_i, m2_adr_i, m2_dat_i,
    input  m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_ack_o, m1_err_o, m1_dat_o,
    input  m2_ack_o, m2_err_o, m2_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i
  );
endinterface

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter giving three Wishbone classic masters access to one shared-RAM data port.
// One transaction at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE, all outputs registered.
module wb_data_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_data_arbiter_if.slave bus,
  output logic [2:0]       grant_o,
  output logic             busy_o
);

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [7:0]          timer_q, timer_d;
  logic                abort_q, abort_d;
  logic [2:0]          grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                s_cyc_q, s_cyc_d, s_stb_q, s_stb_d, s_we_q, s_we_d;
  logic [DW-1:0]       s_adr_q, s_adr_d, s_dat_q, s_dat_d;
  logic [2:0]          ack_q, ack_d, err_q, err_d;
  logic [2:0][DW-1:0]  rdat_q, rdat_d;

  logic [3:0]          req;
  logic [2:0]          cyc;
  logic [1:0]          prio [3];
  logic                pick_valid;
  logic [1:0]          pick_idx;
  logic                grant_now;
  logic                granted_cyc;
  logic                ack_seen;
  logic                sel_we;
  logic [DW-1:0]       sel_adr, sel_dat;

  // Padded to 4 bits so a 2-bit index never leaves the vector.
  assign req = {1'b0, bus.m2_cyc_i & bus.m2_stb_i, bus.m1_cyc_i & bus.m1_stb_i,
                bus.m0_cyc_i & bus.m0_stb_i};
  assign cyc = {bus.m2_cyc_i, bus.m1_cyc_i, bus.m0_cyc_i};
  assign granted_cyc = |(grant_q & cyc);
  assign grant_now = (state_q == StIdle) && pick_valid;

  // Round-robin pick: the master after the last winner has top priority.
  always_comb begin
    prio = '{2'd0, 2'd1, 2'd2};
    unique case (last_q)
      2'd0:    prio = '{2'd1, 2'd2, 2'd0};
      2'd1:    prio = '{2'd2, 2'd0, 2'd1};
      default: prio = '{2'd0, 2'd1, 2'd2};
    endcase
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    // Walk from lowest to highest priority so the highest requester wins.
    for (int k = 2; k >= 0; k--) begin
      if (req[prio[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = prio[k];
      end
    end
  end

  // Request fields of the master being granted.
  always_comb begin
    unique case (pick_idx)
      2'd1:    begin sel_adr = bus.m1_adr_i; sel_dat = bus.m1_dat_i; sel_we = bus.m1_we_i; end
      2'd2:    begin sel_adr = bus.m2_adr_i; sel_dat = bus.m2_dat_i; sel_we = bus.m2_we_i; end
      default: begin sel_adr = bus.m0_adr_i; sel_dat = bus.m0_dat_i; sel_we = bus.m0_we_i; end
    endcase
  end

  // State register together with the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 2'd2;
      timer_q <= '0;
      abort_q <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      abort_q <= abort_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      s_cyc_q <= s_cyc_d;
      s_stb_q <= s_stb_d;
      s_we_q  <= s_we_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Next-state logic; abort remembers the owner dropping cyc while the slave cycle runs.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    timer_d  = timer_q;
    abort_d  = abort_q;
    ack_seen = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StReq;
          last_d  = pick_idx;
          abort_d = 1'b0;
        end
      end
      StReq: begin
        state_d = StWait;
        timer_d = '0;
        abort_d = abort_q | ~granted_cyc;
      end
      StWait: begin
        timer_d = timer_q + 8'd1;
        abort_d = abort_q | ~granted_cyc;
        // Slave ack wins over a timeout landing in the same cycle.
        if (bus.s_ack_i) begin
          state_d  = StResp;
          ack_seen = 1'b1;
        end else if (timer_q == TimerLast) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next-values, derived from the upcoming state so every output is a flop.
  always_comb begin
    grant_d = grant_q;
    s_we_d  = s_we_q;
    s_adr_d = s_adr_q;
    s_dat_d = s_dat_q;
    s_cyc_d = (state_d == StReq) || (state_d == StWait);
    s_stb_d = (state_d == StReq);
    busy_d  = (state_d != StIdle);
    ack_d   = '0;
    err_d   = '0;
    rdat_d  = '0;
    if (grant_now) begin
      grant_d = 3'b001 << pick_idx;
      s_adr_d = sel_adr;
      s_dat_d = sel_dat;
      s_we_d  = sel_we;
    end else if (state_d == StIdle) begin
      grant_d = '0;
    end
    if (!s_cyc_d) begin
      s_adr_d = '0;
      s_dat_d = '0;
      s_we_d  = 1'b0;
    end
    if ((state_q == StWait) && (state_d == StResp) && !abort_d) begin
      if (ack_seen) begin
        ack_d = grant_q;
        for (int i = 0; i < 3; i++) begin
          if (grant_q[i]) rdat_d[i] = bus.s_dat_i;
        end
      end else begin
        err_d = grant_q;
      end
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign bus.s_cyc_o  = s_cyc_q;
  assign bus.s_stb_o  = s_stb_q;
  assign bus.s_we_o   = s_we_q;
  assign bus.s_adr_o  = s_adr_q;
  assign bus.s_dat_o  = s_dat_q;
  assign bus.m0_ack_o = ack_q[0];
  assign bus.m1_ack_o = ack_q[1];
  assign bus.m2_ack_o = ack_q[2];
  assign bus.m0_err_o = err_q[0];
  assign bus.m1_err_o = err_q[1];
  assign bus.m2_err_o = err_q[2];
  assign bus.m0_dat_o = rdat_q[0];
  assign bus.m1_dat_o = rdat_q[1];
  assign bus.m2_dat_o = rdat_q[2];

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Bench for wb_data_arbiter: directed scenarios plus random traffic from three masters,
// checked against a transaction-level round-robin model and per-master shadow memories.
module tb_wb_data_arbiter;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_data_arbiter_if #(.DW(DW)) bus ();
  logic [2:0] grant_o;
  logic       busy_o;

  wb_data_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .grant_o(grant_o),
    .busy_o (busy_o)
  );

  // Master-side drive
  logic          m_cyc [3];
  logic          m_stb [3];
  logic          m_we  [3];
  logic [DW-1:0] m_adr [3];
  logic [DW-1:0] m_dat [3];
  assign bus.m0_cyc_i = m_cyc[0]; assign bus.m0_stb_i = m_stb[0]; assign bus.m0_we_i = m_we[0];
  assign bus.m1_cyc_i = m_cyc[1]; assign bus.m1_stb_i = m_stb[1]; assign bus.m1_we_i = m_we[1];
  assign bus.m2_cyc_i = m_cyc[2]; assign bus.m2_stb_i = m_stb[2]; assign bus.m2_we_i = m_we[2];
  assign bus.m0_adr_i = m_adr[0]; assign bus.m0_dat_i = m_dat[0];
  assign bus.m1_adr_i = m_adr[1]; assign bus.m1_dat_i = m_dat[1];
  assign bus.m2_adr_i = m_adr[2]; assign bus.m2_dat_i = m_dat[2];

  logic [2:0]    ack_v, err_v;
  logic [DW-1:0] dat_v [3];
  assign ack_v = {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o};
  assign err_v = {bus.m2_err_o, bus.m1_err_o, bus.m0_err_o};
  assign dat_v[0] = bus.m0_dat_o;
  assign dat_v[1] = bus.m1_dat_o;
  assign dat_v[2] = bus.m2_dat_o;

  // Shared RAM: acks one cycle after cyc&stb unless muted
  logic [DW-1:0] mem [64];
  logic          ram_ack;
  logic [DW-1:0] ram_rdat;
  logic          mute;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_ack  <= 1'b0;
      ram_rdat <= '0;
    end else begin
      ram_ack  <= bus.s_cyc_o & bus.s_stb_o & ~mute;
      ram_rdat <= '0;
      if (bus.s_cyc_o && bus.s_stb_o && !mute) begin
        ram_rdat <= mem[bus.s_adr_o[7:2]];
        if (bus.s_we_o) mem[bus.s_adr_o[7:2]] <= bus.s_dat_o;
      end
    end
  end
  assign bus.s_ack_i = ram_ack;
  assign bus.s_dat_i = ram_rdat;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [2:0] g);
    return g[2] ? 2 : (g[1] ? 1 : 0);
  endfunction

  // Monitor: event counters, grant log and the random-phase reference model
  int         edge_n = 0;
  logic [2:0] req_s = '0;
  int         stb_cnt = 0, sack_cnt = 0;
  int         ack_cnt [3] = '{0, 0, 0};
  int         err_cnt [3] = '{0, 0, 0};
  int         glog_idx [$];
  int         glog_edge [$];
  logic [2:0] prev_grant = '0;

  logic       model_on = 1'b0;
  int         mdl_last, mdl_next_ok, mdl_gidx, mdl_gedge;
  logic       mdl_valid;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    req_s  <= {m_cyc[2] & m_stb[2], m_cyc[1] & m_stb[1], m_cyc[0] & m_stb[0]};
  end

  always @(negedge clk) begin
    logic [2:0] exp_g, exp_a;
    if (bus.s_stb_o) stb_cnt++;
    if (ram_ack) sack_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (ack_v[i]) ack_cnt[i]++;
      if (err_v[i]) err_cnt[i]++;
    end
    if (grant_o != 3'b000 && prev_grant == 3'b000) begin
      glog_idx.push_back(idx_of(grant_o));
      glog_edge.push_back(edge_n);
    end
    prev_grant = grant_o;
    if (model_on) begin
      // Each transaction with a one-cycle slave occupies four edges, IDLE included.
      if (edge_n >= mdl_next_ok && req_s != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (mdl_last + k) % 3;
          if (req_s[c]) begin
            mdl_gidx = c;
            break;
          end
        end
        mdl_last    = mdl_gidx;
        mdl_gedge   = edge_n;
        mdl_next_ok = edge_n + 4;
        mdl_valid   = 1'b1;
      end
      exp_g = (mdl_valid && edge_n - mdl_gedge <= 2) ? 3'(1 << mdl_gidx) : 3'b000;
      exp_a = (mdl_valid && edge_n - mdl_gedge == 2) ? 3'(1 << mdl_gidx) : 3'b000;
      check_eq("rnd_grant", grant_o, exp_g);
      check_eq("rnd_busy", busy_o, exp_g != 3'b000);
      check_eq("rnd_ack", ack_v, exp_a);
      check_eq("rnd_err", err_v, 0);
      for (int i = 0; i < 3; i++) begin
        if (!ack_v[i]) check_eq("rnd_dat_idle", dat_v[i], 0);
      end
    end
  end

  // One master transaction; called at a negedge, returns at the negedge ack/err is seen.
  task automatic do_xfer(input int m, input logic we, input logic [DW-1:0] adr,
                         input logic [DW-1:0] wdat, input int bound,
                         output logic [DW-1:0] rdat, output logic got_ack, output logic got_err,
                         output int lat, output logic [2:0] gnt1, output logic hold_ok);
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we; m_adr[m] = adr; m_dat[m] = wdat;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; hold_ok = 1'b1; gnt1 = '0; rdat = '0;
    while (!(got_ack || got_err) && lat < bound) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) gnt1 = grant_o;
      if (grant_o == 3'(1 << m) && bus.s_cyc_o) begin
        if (bus.s_adr_o != adr || bus.s_we_o != we || (we && bus.s_dat_o != wdat))
          hold_ok = 1'b0;
      end
      got_ack = ack_v[m];
      got_err = err_v[m];
      rdat    = dat_v[m];
    end
    check_eq("xfer_done", got_ack | got_err, 1);
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
  endtask

  // Random traffic for one master in its own address window, against a private shadow copy
  task automatic run_master(input int m, input int n);
    logic [DW-1:0] shadow [16];
    logic          vld [16];
    logic [DW-1:0] adr, wd, rd;
    logic          ga, ge, ho;
    logic [2:0]    g1;
    int            lat, w;
    for (int i = 0; i < 16; i++) vld[i] = 1'b0;
    @(negedge clk);
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w   = int'($urandom_range(0, 15));
      adr = 32'h2000 | (32'(m) << 6) | (32'(w) << 2);
      if (!vld[w] || $urandom_range(0, 1) == 1) begin
        wd = $urandom;
        do_xfer(m, 1'b1, adr, wd, 100, rd, ga, ge, lat, g1, ho);
        check_eq("rnd_wr_ack", ga, 1);
        check_eq("rnd_wr_hold", ho, 1);
        shadow[w] = wd;
        vld[w]    = 1'b1;
      end else begin
        do_xfer(m, 1'b0, adr, '0, 100, rd, ga, ge, lat, g1, ho);
        check_eq("rnd_rd_ack", ga, 1);
        check_eq("rnd_rd_data", rd, shadow[w]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    logic          ga, ge, ho;
    logic [2:0]    g1;
    int            lat, s0, a0, e0, k0;
    for (int i = 0; i < 3; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; m_adr[i] = '0; m_dat[i] = '0;
    end
    mute  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_grant", grant_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_s_cyc_stb", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}, 0);
    check_eq("rst_ack_err", {ack_v, err_v}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read after seeding the location
    do_xfer(0, 1'b1, 32'h1004, 32'hDEADBEEF, 20, rd, ga, ge, lat, g1, ho);
    check_eq("seed_ack", ga, 1);
    @(negedge clk);
    s0 = stb_cnt;
    do_xfer(0, 1'b0, 32'h1004, '0, 20, rd, ga, ge, lat, g1, ho);
    check_eq("rd_ack", ga, 1);
    check_eq("rd_latency", lat, 3);
    check_eq("rd_data", rd, 32'hDEADBEEF);
    check_eq("rd_grant", g1, 3'b001);
    check_eq("rd_stb_cycles", stb_cnt - s0, 1);
    @(negedge clk);

    // Write from m2
    s0 = stb_cnt; a0 = ack_cnt[2];
    do_xfer(2, 1'b1, 32'h1010, 32'h12345678, 20, rd, ga, ge, lat, g1, ho);
    check_eq("wr_ack", ga, 1);
    check_eq("wr_hold", ho, 1);
    check_eq("wr_grant", g1, 3'b100);
    repeat (3) @(negedge clk);
    check_eq("wr_stb_count", stb_cnt - s0, 1);
    check_eq("wr_ack_pulses", ack_cnt[2] - a0, 1);
    check_eq("wr_mem", mem[6'h04], 32'h12345678);

    // Timeout on m1
    mute = 1'b1; a0 = ack_cnt[1]; e0 = err_cnt[1];
    do_xfer(1, 1'b0, 32'h1008, '0, 40, rd, ga, ge, lat, g1, ho);
    check_eq("to_err", ge, 1);
    check_eq("to_latency", lat, 18);
    check_eq("to_dat_zero", rd, 0);
    @(negedge clk);
    check_eq("to_idle", busy_o, 0);
    check_eq("to_no_ack", ack_cnt[1] - a0, 0);
    check_eq("to_err_pulses", err_cnt[1] - e0, 1);
    mute = 1'b0;

    // Contention from reset, requests held
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    glog_idx.delete(); glog_edge.delete();
    for (int i = 0; i < 3; i++) begin
      m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = 1'b0; m_adr[i] = 32'h1000 + 32'(i * 4);
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin m_cyc[i] = 1'b0; m_stb[i] = 1'b0; end
    check_eq("cont_count", glog_idx.size() >= 4, 1);
    if (glog_idx.size() >= 4) begin
      check_eq("cont_g0", glog_idx[0], 0);
      check_eq("cont_g1", glog_idx[1], 1);
      check_eq("cont_g2", glog_idx[2], 2);
      check_eq("cont_g3", glog_idx[3], 0);
      for (int k = 0; k < 3; k++) check_eq("cont_spacing", glog_edge[k+1] - glog_edge[k], 4);
    end
    repeat (5) @(negedge clk);

    // Abort: m1 drops cyc in WAIT
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    a0 = ack_cnt[1]; e0 = err_cnt[1]; k0 = sack_cnt;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h1008;
    @(posedge clk); @(negedge clk);
    check_eq("ab_grant", grant_o, 3'b010);
    @(posedge clk); @(negedge clk);
    check_eq("ab_wait", {bus.s_cyc_o, bus.s_stb_o}, 2'b10);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("ab_no_ack", ack_cnt[1] - a0, 0);
    check_eq("ab_no_err", err_cnt[1] - e0, 0);
    check_eq("ab_slave_done", sack_cnt - k0, 1);
    check_eq("ab_idle", busy_o, 0);
    for (int i = 0; i < 3; i++) begin m_cyc[i] = 1'b1; m_stb[i] = 1'b1; end
    @(posedge clk); @(negedge clk);
    check_eq("ab_next_rr", grant_o, 3'b100);
    for (int i = 0; i < 3; i++) begin m_cyc[i] = 1'b0; m_stb[i] = 1'b0; end
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-WAIT
    a0 = ack_cnt[0]; e0 = err_cnt[0];
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h1004;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_eq("ar_in_wait", grant_o, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_grant_busy", {grant_o, busy_o}, 0);
    check_eq("ar_s_ctl", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}, 0);
    check_eq("ar_s_adr", bus.s_adr_o, 0);
    check_eq("ar_m_out", {ack_v, err_v}, 0);
    check_eq("ar_m0_dat", dat_v[0], 0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("ar_no_ack", ack_cnt[0] - a0, 0);
    check_eq("ar_no_err", err_cnt[0] - e0, 0);

    // Random traffic against the reference model
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    mdl_last = 2; mdl_next_ok = 0; mdl_valid = 1'b0; mdl_gidx = 0; mdl_gedge = 0;
    model_on = 1'b1;
    fork
      run_master(0, 25);
      run_master(1, 25);
      run_master(2, 25);
    join
    repeat (6) @(negedge clk);
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
